// File: rtl/ysyx_23060203_alu_arb_pkg.sv
// Shared ALU definitions: funct encodings in RISC-V funct3 order and the
// arbiter sequencing states.
package ysyx_23060203_alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SHL = 3'd1;
    localparam logic [2:0] ALU_LTS = 3'd2;
    localparam logic [2:0] ALU_LTU = 3'd3;
    localparam logic [2:0] ALU_XOR = 3'd4;
    localparam logic [2:0] ALU_SHR = 3'd5;
    localparam logic [2:0] ALU_OR  = 3'd6;
    localparam logic [2:0] ALU_AND = 3'd7;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_EXEC = 2'd1,
        ARB_RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ysyx_23060203_alu_arb_rr_pick.sv
// Combinational round-robin picker: first valid requester after ptr,
// wrapping modulo N; returns a one-hot grant and its index.
module ysyx_23060203_rr_pick #(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]   valid,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] index
);

    logic found;
    int   j;

    always_comb begin
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IDW'(j);
            end
        end
    end

endmodule

// File: rtl/ysyx_23060203_alu_arb.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between N requesters.
// Optional statistics counters enabled by YSYX_23060203_ALU_ARB_STAT_EN.
//
// state    | meaning
// ARB_IDLE | no operation in flight; grant slot open
// ARB_EXEC | op regs drive the ALU; result captured at end of cycle
// ARB_RESP | result presented to owner; grant slot opens on response handshake
module ysyx_23060203_alu_arb
    import ysyx_23060203_alu_pkg::*;
#(
    parameter int N   = 2,
    parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req_valid,
    output logic [N-1:0]    req_ready,
    input  logic [N*32-1:0] req_a,
    input  logic [N*32-1:0] req_b,
    input  logic [N*3-1:0]  req_funct,
    input  logic [N-1:0]    req_funcs,
    output logic [N-1:0]    resp_valid,
    input  logic [N-1:0]    resp_ready,
    output logic [31:0]     resp_val,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    output logic [2:0]      alu_funct,
    output logic            alu_funcs,
    input  logic [31:0]     alu_val
`ifdef YSYX_23060203_ALU_ARB_STAT_EN
    ,
    output logic [N*32-1:0] stat_grant,
    output logic [31:0]     stat_stall
`endif
);

    arb_state_e     state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] owner;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic [2:0]     op_funct;
    logic           op_funcs;
    logic [31:0]    result;

    logic [N-1:0]   pick_grant;
    logic [IDW-1:0] pick_idx;
    logic           resp_hs;
    logic           slot_open;
    logic           req_hs;

    ysyx_23060203_rr_pick #(.N(N), .IDW(IDW)) u_pick (
        .valid (req_valid),
        .ptr   (ptr),
        .grant (pick_grant),
        .index (pick_idx)
    );

    // Back-to-back service: a response handshake frees the slot in the same cycle.
    assign resp_hs   = (state == ARB_RESP) && resp_ready[owner];
    assign slot_open = (state == ARB_IDLE) || resp_hs;
    assign req_hs    = slot_open && (|req_valid);
    assign req_ready = slot_open ? pick_grant : '0;

    always_comb begin
        resp_valid = '0;
        if (state == ARB_RESP)
            resp_valid[owner] = 1'b1;
    end

    assign resp_val  = (state == ARB_RESP) ? result : 32'd0;

    assign alu_a     = op_a;
    assign alu_b     = op_b;
    assign alu_funct = op_funct;
    assign alu_funcs = op_funcs;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB_IDLE;
            ptr      <= IDW'(N - 1);
            owner    <= '0;
            op_a     <= '0;
            op_b     <= '0;
            op_funct <= '0;
            op_funcs <= 1'b0;
            result   <= '0;
        end else begin
            if (req_hs) begin
                op_a     <= req_a[32*int'(pick_idx) +: 32];
                op_b     <= req_b[32*int'(pick_idx) +: 32];
                op_funct <= req_funct[3*int'(pick_idx) +: 3];
                op_funcs <= req_funcs[pick_idx];
                owner    <= pick_idx;
                ptr      <= pick_idx;
            end
            case (state)
                ARB_IDLE: begin
                    if (req_hs)
                        state <= ARB_EXEC;
                end
                ARB_EXEC: begin
                    result <= alu_val;
                    state  <= ARB_RESP;
                end
                ARB_RESP: begin
                    if (resp_hs)
                        state <= req_hs ? ARB_EXEC : ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

`ifdef YSYX_23060203_ALU_ARB_STAT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_grant <= '0;
            stat_stall <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i])
                    stat_grant[32*i +: 32] <= stat_grant[32*i +: 32] + 32'd1;
            end
            if ((|req_valid) && !(|req_ready))
                stat_stall <= stat_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_23060203_alu_arb.sv
// Directed bench for ysyx_23060203_alu_arb with a behavioural ALU on alu_*.
module tb_ysyx_23060203_alu_arb;
    import ysyx_23060203_alu_pkg::*;

    localparam int N = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N*3-1:0]  req_funct;
    logic [N-1:0]    req_funcs;
    logic [N-1:0]    resp_valid;
    logic [N-1:0]    resp_ready;
    logic [31:0]     resp_val;
    logic [31:0]     alu_a;
    logic [31:0]     alu_b;
    logic [2:0]      alu_funct;
    logic            alu_funcs;
    logic [31:0]     alu_val;
`ifdef YSYX_23060203_ALU_ARB_STAT_EN
    logic [N*32-1:0] stat_grant;
    logic [31:0]     stat_stall;
`endif

    int tests = 0;
    int fails = 0;

    ysyx_23060203_alu_arb #(.N(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_funct  (req_funct),
        .req_funcs  (req_funcs),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_val   (resp_val),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_funct  (alu_funct),
        .alu_funcs  (alu_funcs),
        .alu_val    (alu_val)
`ifdef YSYX_23060203_ALU_ARB_STAT_EN
        ,
        .stat_grant (stat_grant),
        .stat_stall (stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f, input logic s);
        case (f)
            ALU_ADD: alu_f = s ? a - b : a + b;
            ALU_SHL: alu_f = a << b[4:0];
            ALU_LTS: alu_f = {31'd0, $signed(a) < $signed(b)};
            ALU_LTU: alu_f = {31'd0, a < b};
            ALU_XOR: alu_f = a ^ b;
            ALU_SHR: alu_f = s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            ALU_OR:  alu_f = a | b;
            default: alu_f = a & b;
        endcase
    endfunction

    assign alu_val = alu_f(alu_a, alu_b, alu_funct, alu_funcs);

    typedef struct {
        int          r;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f;
        logic        s;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] f, input logic s);
        req_a[32*r +: 32] = a;
        req_b[32*r +: 32] = b;
        req_funct[3*r +: 3] = f;
        req_funcs[r] = s;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        int   lat;
        bit   seen;
        v = vecs[i];
        @(negedge clk);
        resp_ready = '0;
        req_valid = '0;
        req_valid[v.r] = 1'b1;
        set_req(v.r, v.a, v.b, v.f, v.s);
        #1 chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(1 << v.r));
        @(negedge clk);
        req_valid = '0;
        seen = 1'b0;
        lat = 1;
        while (!seen && lat < 10) begin
            #1;
            if (resp_valid != '0) seen = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
        chk($sformatf("v%0d_resp_valid", i), 32'(resp_valid), 32'(1 << v.r));
        chk($sformatf("v%0d_resp_val", i), resp_val, v.exp);
        chk($sformatf("v%0d_alu_a", i), alu_a, v.a);
        resp_ready[v.r] = 1'b1;
        @(negedge clk);
        resp_ready = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    logic [1:0]  c_rdy [9];
    logic [1:0]  c_rv  [9];
    logic [31:0] c_val [9];

    initial begin
        vecs[0]  = '{0, 32'd5,          32'd3,          ALU_ADD, 1'b1, 32'd2};
        vecs[1]  = '{1, 32'd7,          32'd8,          ALU_ADD, 1'b0, 32'd15};
        vecs[2]  = '{0, 32'h8000_0000,  32'h24,         ALU_SHR, 1'b1, 32'hF800_0000};
        vecs[3]  = '{1, 32'h8000_0000,  32'd4,          ALU_SHR, 1'b0, 32'h0800_0000};
        vecs[4]  = '{0, 32'd1,          32'hFFFF_FFFF,  ALU_LTU, 1'b0, 32'd1};
        vecs[5]  = '{1, 32'hFFFF_FFFF,  32'd1,          ALU_LTS, 1'b0, 32'd1};
        vecs[6]  = '{0, 32'd1,          32'hFFFF_FFFF,  ALU_LTS, 1'b0, 32'd0};
        vecs[7]  = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  ALU_XOR, 1'b0, 32'h0000_FF00};
        vecs[8]  = '{0, 32'h0000_F0F0,  32'h0000_0FF0,  ALU_OR,  1'b0, 32'h0000_FFF0};
        vecs[9]  = '{1, 32'h0000_F0F0,  32'h0000_0FF0,  ALU_AND, 1'b0, 32'h0000_00F0};
        vecs[10] = '{0, 32'd1,          32'd31,         ALU_SHL, 1'b0, 32'h8000_0000};

        // Contention schedule: grants alternate 0,1,0,1; results 3 (ADD) and 1 (LTS).
        c_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00};
        c_rv  = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
        c_val = '{32'd0, 32'd0, 32'd3, 32'd0, 32'd1, 32'd0, 32'd3, 32'd0, 32'd1};

        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_funct = '0;
        req_funcs = '0;
        resp_ready = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_val", resp_val, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_fn", {28'd0, alu_funct, alu_funcs}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) run_vec(i);

        // Idle: op regs must not follow req_* inputs.
        @(negedge clk);
        req_a = '1;
        req_b = '1;
        req_funct = '0;
        #1;
        chk("idle_alu_a_hold", alu_a, 32'd1);
        chk("idle_alu_b_hold", alu_b, 32'd31);
        chk("idle_alu_funct_hold", 32'(alu_funct), 32'(ALU_SHL));

        // Continuous contention after reset.
        pulse_reset();
        set_req(0, 32'd1, 32'd2, ALU_ADD, 1'b0);
        set_req(1, 32'hFFFF_FFFF, 32'd1, ALU_LTS, 1'b0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            req_valid = (k == 8) ? 2'b00 : 2'b11;
            resp_ready = 2'b11;
            #1;
            chk($sformatf("cont%0d_req_ready", k), 32'(req_ready), 32'(c_rdy[k]));
            chk($sformatf("cont%0d_resp_valid", k), 32'(resp_valid), 32'(c_rv[k]));
            chk($sformatf("cont%0d_resp_val", k), resp_val, c_val[k]);
        end
        @(negedge clk);
        resp_ready = '0;
        #1 chk("cont_idle_resp_valid", 32'(resp_valid), 32'd0);

        // Backpressure on req0 while req1 waits; resp_ready[1] is a non-owner bit.
        @(negedge clk);
        set_req(0, 32'd10, 32'd20, ALU_ADD, 1'b0);
        set_req(1, 32'd100, 32'd1, ALU_ADD, 1'b1);
        req_valid = 2'b01;
        #1 chk("bp_grant0", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = 2'b10;
        #1 chk("bp_exec_ready", 32'(req_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            resp_ready = 2'b10;
            #1;
            chk($sformatf("bp%0d_resp_valid", k), 32'(resp_valid), 32'b01);
            chk($sformatf("bp%0d_resp_val", k), resp_val, 32'd30);
            chk($sformatf("bp%0d_req_ready", k), 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        resp_ready = 2'b01;
        #1;
        chk("bp_release_grant1", 32'(req_ready), 32'b10);
        chk("bp_release_resp_valid", 32'(resp_valid), 32'b01);
        @(negedge clk);
        req_valid = '0;
        resp_ready = '0;
        #1 chk("bp_exec1_resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("bp_resp1_valid", 32'(resp_valid), 32'b10);
        chk("bp_resp1_val", resp_val, 32'd99);
        resp_ready = 2'b10;
        @(negedge clk);
        resp_ready = '0;

        // Reset while a response is pending.
        @(negedge clk);
        set_req(0, 32'd6, 32'd7, ALU_ADD, 1'b0);
        req_valid = 2'b01;
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        #1 chk("rr_pre_resp_valid", 32'(resp_valid), 32'b01);
        #1 rst = 1'b1;
        #1;
        chk("rr_async_resp_valid", 32'(resp_valid), 32'd0);
        chk("rr_async_resp_val", resp_val, 32'd0);
        chk("rr_async_alu_a", alu_a, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1 chk($sformatf("rr_no_stale%0d", k), 32'(resp_valid), 32'd0);
        end
        @(negedge clk);
        req_valid = 2'b11;
        #1 chk("rr_ptr_reset_grant", 32'(req_ready), 32'b01);
        @(negedge clk);
        req_valid = '0;
        @(negedge clk);
        resp_ready = 2'b11;
        #1;
        chk("rr_after_resp_valid", 32'(resp_valid), 32'b01);
        chk("rr_after_resp_val", resp_val, 32'd13);
        @(negedge clk);
        resp_ready = '0;

`ifdef YSYX_23060203_ALU_ARB_STAT_EN
        // Three grants to req1 with two EXEC-cycle stalls.
        pulse_reset();
        set_req(1, 32'd1, 32'd1, ALU_ADD, 1'b0);
        resp_ready = 2'b10;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            req_valid = (k < 5) ? 2'b10 : 2'b00;
        end
        #1;
        chk("stat_grant0", stat_grant[31:0], 32'd0);
        chk("stat_grant1", stat_grant[63:32], 32'd3);
        chk("stat_stall", stat_stall, 32'd2);
        resp_ready = '0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
